// File: rtl/sr_decrementer_pkg.sv
// ----------------------------------------------------------------------------
// Package: sr_counter_pkg
// Purpose: Shared types and defaults for the sr_decrementer loadable
//          down-counter. It provides the two-state controller encoding and the
//          default counter width.
// Contents:
//   sr_state_t  IDLE / RUN controller state
//   SR_LENGTH   default counter width in bits
// ----------------------------------------------------------------------------
package sr_counter_pkg;

    localparam int SR_LENGTH = 14;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sr_state_t;

endpackage : sr_counter_pkg

// File: rtl/sr_decrementer_if.sv
// ----------------------------------------------------------------------------
// Interface: sr_decrementer_if
// Purpose: Groups the command and status signals of sr_decrementer.
// Signals:
//   enable      master->slave  decrement request for this cycle
//   load        master->slave  load load_value this cycle (priority over enable)
//   load_value  master->slave  iteration count to load
//   out         slave->master  current count (registered)
//   zero        slave->master  out == 0
//   busy        slave->master  counter is running
//   done        slave->master  one-cycle terminal-count pulse
// ----------------------------------------------------------------------------
interface sr_decrementer_if #(
    parameter int length = 14
);

    logic              enable;
    logic              load;
    logic [length-1:0] load_value;
    logic [length-1:0] out;
    logic              zero;
    logic              busy;
    logic              done;

    modport master (
        output enable,
        output load,
        output load_value,
        input  out,
        input  zero,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  load,
        input  load_value,
        output out,
        output zero,
        output busy,
        output done
    );

endinterface : sr_decrementer_if

// File: rtl/sr_decrementer.sv
// ----------------------------------------------------------------------------
// Module: sr_decrementer
// Purpose: Synchronous loadable down-counter. It is loaded with an iteration
//          count, decrements once per enabled clock while running, and pulses
//          done on terminal count. With WRAP=1 the last loaded value is
//          reloaded on terminal count, so back-to-back streams run without a
//          gap.
// Parameters:
//   length  counter width in bits
//   WRAP    0: stop at zero and go idle; 1: auto-reload on terminal count
// Ports:
//   clk    in   clock, all flops on posedge
//   reset  in   synchronous active-high reset (overrides load and enable)
//   bus    slave modport of sr_decrementer_if (enable, load, load_value in;
//          out, zero, busy, done out)
// ----------------------------------------------------------------------------
module sr_decrementer
    import sr_counter_pkg::*;
#(
    parameter int length = SR_LENGTH,
    parameter int WRAP   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    sr_decrementer_if.slave       bus
);

    localparam logic [length-1:0] ZERO_C = {length{1'b0}};
    localparam logic [length-1:0] ONE_C  = {{(length-1){1'b0}}, 1'b1};

    sr_state_t         state_r;
    sr_state_t         state_s;
    logic [length-1:0] out_r;
    logic [length-1:0] out_s;
    logic [length-1:0] reload_r;
    logic [length-1:0] reload_s;
    logic              done_r;
    logic              done_s;

    // Next-state / next-count decode: load beats enable, enable beats hold.
    always_comb begin
        state_s  = state_r;
        out_s    = out_r;
        reload_s = reload_r;
        done_s   = 1'b0;
        if (bus.load) begin
            if (bus.load_value != ZERO_C) begin
                // A load during RUN simply restarts the count; any enable
                // presented in the same cycle is dropped.
                out_s    = bus.load_value;
                reload_s = bus.load_value;
                state_s  = RUN;
            end else begin
                // Empty job: finish immediately with a done pulse.
                out_s   = ZERO_C;
                state_s = IDLE;
                done_s  = 1'b1;
            end
        end else if (bus.enable) begin
            case (state_r)
                RUN: begin
                    if (out_r > ONE_C) begin
                        out_s = out_r - ONE_C;
                    end else begin
                        // Terminal count is detected at 1, never at 0, so
                        // the subtraction can never borrow.
                        done_s = 1'b1;
                        if (WRAP != 0) begin
                            out_s   = reload_r;
                            state_s = RUN;
                        end else begin
                            out_s   = ZERO_C;
                            state_s = IDLE;
                        end
                    end
                end
                IDLE: begin
                    out_s   = out_r;
                    state_s = IDLE;
                end
                default: begin
                    out_s   = ZERO_C;
                    state_s = IDLE;
                end
            endcase
        end else begin
            out_s   = out_r;
            state_s = state_r;
        end
    end

    // State, count, reload and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            out_r    <= ZERO_C;
            reload_r <= ZERO_C;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            out_r    <= out_s;
            reload_r <= reload_s;
            done_r   <= done_s;
        end
    end

    assign bus.out  = out_r;
    assign bus.zero = (out_r == ZERO_C);
    assign bus.busy = (state_r == RUN);
    assign bus.done = done_r;

endmodule : sr_decrementer

// File: tb/tb_sr_decrementer.sv
// ----------------------------------------------------------------------------
// Testbench: tb_sr_decrementer
// Three instances: 14-bit stop-at-zero (table driven), 14-bit auto-reload and
// 4-bit stop-at-zero (hand-written sequences).
// ----------------------------------------------------------------------------
module tb_sr_decrementer;

    logic clk;
    logic reset;

    int checks;
    int errors;

    sr_decrementer_if #(.length(14)) if0 ();
    sr_decrementer_if #(.length(14)) if1 ();
    sr_decrementer_if #(.length(4))  if2 ();

    sr_decrementer #(.length(14), .WRAP(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    sr_decrementer #(.length(14), .WRAP(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    sr_decrementer #(.length(4),  .WRAP(0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        load;
        logic        en;
        logic [13:0] lv;
        logic [13:0] exp_out;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic rst, input logic load,
                                input logic en, input int lv, input int eo,
                                input logic eb, input logic ed, input logic ez);
        vec_t v;
        v.name     = name;
        v.rst      = rst;
        v.load     = load;
        v.en       = en;
        v.lv       = 14'(lv);
        v.exp_out  = 14'(eo);
        v.exp_busy = eb;
        v.exp_done = ed;
        v.exp_zero = ez;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs away from the edge, then sample 1 time unit after posedge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic rst, input logic ld, input logic en, input logic [13:0] lv);
        @(negedge clk);
        reset          = rst;
        if0.load       = ld;
        if0.enable     = en;
        if0.load_value = lv;
        tick();
    endtask

    task automatic drive1(input logic ld, input logic en, input logic [13:0] lv);
        @(negedge clk);
        if1.load       = ld;
        if1.enable     = en;
        if1.load_value = lv;
        tick();
    endtask

    task automatic drive2(input logic ld, input logic en, input logic [3:0] lv);
        @(negedge clk);
        if2.load       = ld;
        if2.enable     = en;
        if2.load_value = lv;
        tick();
    endtask

    task automatic chk1(input string name, input int eo, input int eb, input int ed);
        check({name, "_out"},  int'(if1.out),  eo);
        check({name, "_busy"}, int'(if1.busy), eb);
        check({name, "_done"}, int'(if1.done), ed);
    endtask

    task automatic chk2(input string name, input int eo, input int eb, input int ed);
        check({name, "_out"},  int'(if2.out),  eo);
        check({name, "_busy"}, int'(if2.busy), eb);
        check({name, "_done"}, int'(if2.done), ed);
        check({name, "_zero"}, int'(if2.zero), (eo == 0) ? 1 : 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        if0.load = 1'b0; if0.enable = 1'b0; if0.load_value = 14'd0;
        if1.load = 1'b0; if1.enable = 1'b0; if1.load_value = 14'd0;
        if2.load = 1'b0; if2.enable = 1'b0; if2.load_value = 4'd0;

        //    name       rst  ld   en   lv     out    busy done zero
        add("rst",       1'b1,1'b1,1'b1,   5,      0, 1'b0,1'b0,1'b1);
        // 1: load 5, five enables
        add("t1_ld5",    1'b0,1'b1,1'b0,   5,      5, 1'b1,1'b0,1'b0);
        add("t1_e4",     1'b0,1'b0,1'b1,   0,      4, 1'b1,1'b0,1'b0);
        add("t1_e3",     1'b0,1'b0,1'b1,   0,      3, 1'b1,1'b0,1'b0);
        add("t1_e2",     1'b0,1'b0,1'b1,   0,      2, 1'b1,1'b0,1'b0);
        add("t1_e1",     1'b0,1'b0,1'b1,   0,      1, 1'b1,1'b0,1'b0);
        add("t1_e0",     1'b0,1'b0,1'b1,   0,      0, 1'b0,1'b1,1'b1);
        add("t1_idle",   1'b0,1'b0,1'b0,   0,      0, 1'b0,1'b0,1'b1);
        // 2: load 3, enable 1,0,1,0,1
        add("t2_ld3",    1'b0,1'b1,1'b0,   3,      3, 1'b1,1'b0,1'b0);
        add("t2_e2",     1'b0,1'b0,1'b1,   0,      2, 1'b1,1'b0,1'b0);
        add("t2_h2",     1'b0,1'b0,1'b0,   0,      2, 1'b1,1'b0,1'b0);
        add("t2_e1",     1'b0,1'b0,1'b1,   0,      1, 1'b1,1'b0,1'b0);
        add("t2_h1",     1'b0,1'b0,1'b0,   0,      1, 1'b1,1'b0,1'b0);
        add("t2_e0",     1'b0,1'b0,1'b1,   0,      0, 1'b0,1'b1,1'b1);
        add("t2_after",  1'b0,1'b0,1'b0,   0,      0, 1'b0,1'b0,1'b1);
        // 4: empty job, then enable in IDLE
        add("t4_ld0",    1'b0,1'b1,1'b0,   0,      0, 1'b0,1'b1,1'b1);
        add("t4_en_a",   1'b0,1'b0,1'b1,   0,      0, 1'b0,1'b0,1'b1);
        add("t4_en_b",   1'b0,1'b0,1'b1,   0,      0, 1'b0,1'b0,1'b1);
        // 5: restart by load+enable, then reset mid-run
        add("t5_ld7",    1'b0,1'b1,1'b0,   7,      7, 1'b1,1'b0,1'b0);
        add("t5_e6",     1'b0,1'b0,1'b1,   0,      6, 1'b1,1'b0,1'b0);
        add("t5_e5",     1'b0,1'b0,1'b1,   0,      5, 1'b1,1'b0,1'b0);
        add("t5_e4",     1'b0,1'b0,1'b1,   0,      4, 1'b1,1'b0,1'b0);
        add("t5_ld9en",  1'b0,1'b1,1'b1,   9,      9, 1'b1,1'b0,1'b0);
        add("t5_e8",     1'b0,1'b0,1'b1,   0,      8, 1'b1,1'b0,1'b0);
        add("t5_e7",     1'b0,1'b0,1'b1,   0,      7, 1'b1,1'b0,1'b0);
        add("t5_e6b",    1'b0,1'b0,1'b1,   0,      6, 1'b1,1'b0,1'b0);
        add("t5_rst",    1'b1,1'b0,1'b1,   0,      0, 1'b0,1'b0,1'b1);
        add("t5_post",   1'b0,1'b0,1'b1,   0,      0, 1'b0,1'b0,1'b1);
        // extra: load 0 during RUN ends the job; full-scale load
        add("x_ld4",     1'b0,1'b1,1'b0,   4,      4, 1'b1,1'b0,1'b0);
        add("x_ld0run",  1'b0,1'b1,1'b1,   0,      0, 1'b0,1'b1,1'b1);
        add("x_ldmax",   1'b0,1'b1,1'b0,16383, 16383, 1'b1,1'b0,1'b0);
        add("x_emax",    1'b0,1'b0,1'b1,   0,  16382, 1'b1,1'b0,1'b0);
        add("x_hold",    1'b0,1'b0,1'b0,   0,  16382, 1'b1,1'b0,1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive0(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].lv);
            check({vecs[i].name, "_out"},  int'(if0.out),  int'(vecs[i].exp_out));
            check({vecs[i].name, "_busy"}, int'(if0.busy), int'(vecs[i].exp_busy));
            check({vecs[i].name, "_done"}, int'(if0.done), int'(vecs[i].exp_done));
            check({vecs[i].name, "_zero"}, int'(if0.zero), int'(vecs[i].exp_zero));
        end
        if0.load = 1'b0;
        if0.enable = 1'b0;

        // Reset all instances before the hand-written sequences.
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk1("u1_rst", 0, 0, 0);
        chk2("u2_rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // 3: auto-reload, load 2 then enable held six cycles
        drive1(1'b1, 1'b0, 14'd2);
        chk1("t3_ld2", 2, 1, 0);
        drive1(1'b0, 1'b1, 14'd0); chk1("t3_c1", 1, 1, 0);
        drive1(1'b0, 1'b1, 14'd0); chk1("t3_c2", 2, 1, 1);
        drive1(1'b0, 1'b1, 14'd0); chk1("t3_c3", 1, 1, 0);
        drive1(1'b0, 1'b1, 14'd0); chk1("t3_c4", 2, 1, 1);
        drive1(1'b0, 1'b1, 14'd0); chk1("t3_c5", 1, 1, 0);
        drive1(1'b0, 1'b1, 14'd0); chk1("t3_c6", 2, 1, 1);
        drive1(1'b0, 1'b0, 14'd0); chk1("t3_hold", 2, 1, 0);

        // 6: 4-bit counter, load 15, count down to 0, never wraps
        drive2(1'b1, 1'b0, 4'd15);
        chk2("t6_ld15", 15, 1, 0);
        for (int k = 14; k >= 1; k--) begin
            drive2(1'b0, 1'b1, 4'd0);
            chk2($sformatf("t6_c%0d", k), k, 1, 0);
        end
        drive2(1'b0, 1'b1, 4'd0);
        chk2("t6_term", 0, 0, 1);
        drive2(1'b0, 1'b1, 4'd0);
        chk2("t6_nowrap", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sr_decrementer
